// File: rtl/fsm_pkg.sv
// Shared constants for the s0 AXI slave FSMs (read side and write side).
// Holds the s0 register/FIFO address map, AXI response and burst codes,
// and the one-hot state encoding used by both FSMs.
package fsm_pkg;

  // s0 address map, decoded on araddr[7:0] / awaddr[7:0]
  localparam logic [7:0] ADDR_VARINT_LO = 8'h00;
  localparam logic [7:0] ADDR_VARINT_HI = 8'h01;
  localparam logic [7:0] ADDR_STATUS    = 8'h08;
  localparam logic [7:0] ADDR_RAW       = 8'hF0;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  // Only 32-bit beats are supported
  localparam logic [2:0] SIZE_4B = 3'b010;

  typedef enum logic [3:0] {
    ST_INIT     = 4'b0001,
    ST_AR_READY = 4'b0010,
    ST_FETCH    = 4'b0100,
    ST_R_VALID  = 4'b1000
  } fsm_state_e;

  function automatic logic addr_mapped(input logic [7:0] a);
    return (a == ADDR_VARINT_LO) || (a == ADDR_VARINT_HI) ||
           (a == ADDR_STATUS)    || (a == ADDR_RAW);
  endfunction

endpackage

// File: rtl/axi_rd_fsm.sv
// AXI4 read-channel slave for port s0. Returns results of the varint and
// raw-data engines by popping their show-ahead output FIFOs, and exposes a
// read-only status word.
//
// Ports:
//   clk, reset             clock, async active-low reset
//   axs_s0_ar*             read address channel (araddr[7:0] decoded)
//   axs_s0_r*              read data channel
//   varint_out_q/_empty    64-bit varint FIFO head / empty
//   varint_out_pop         one-cycle pop of the varint FIFO
//   raw_data_out_q/_empty  32-bit raw FIFO head / empty
//   raw_data_out_pop       one-cycle pop of the raw FIFO
//
// Every beat is FETCH -> R_VALID. A beat stuck on an empty FIFO for
// EMPTY_TIMEOUT cycles completes with SLVERR and zero data.
module axi_rd_fsm
  import fsm_pkg::*;
#(
  parameter int EMPTY_TIMEOUT = 1024  // 1..65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  axs_s0_arid,
  input  logic [15:0] axs_s0_araddr,
  input  logic [7:0]  axs_s0_arlen,
  input  logic [2:0]  axs_s0_arsize,
  input  logic [1:0]  axs_s0_arburst,
  input  logic        axs_s0_arvalid,
  output logic        axs_s0_arready,
  output logic [3:0]  axs_s0_rid,
  output logic [31:0] axs_s0_rdata,
  output logic [1:0]  axs_s0_rresp,
  output logic        axs_s0_rlast,
  output logic        axs_s0_rvalid,
  input  logic        axs_s0_rready,
  input  logic [63:0] varint_out_q,
  input  logic        varint_out_empty,
  output logic        varint_out_pop,
  input  logic [31:0] raw_data_out_q,
  input  logic        raw_data_out_empty,
  output logic        raw_data_out_pop
);

  localparam logic [15:0] TMO_LAST = 16'(EMPTY_TIMEOUT - 1);

  fsm_state_e  state_q, state_d;
  logic [3:0]  rid_q, rid_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  beat_q, beat_d;
  logic [15:0] tmo_q, tmo_d;
  logic [15:0] errcnt_q, errcnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;
  logic        err_q, err_d;

  // Only the low address byte is decoded
  logic unused_addr_hi;
  assign unused_addr_hi = ^axs_s0_araddr[15:8];

  // Source readiness and data for the latched address. Status never waits.
  logic        src_ready;
  logic [31:0] src_data;
  logic [15:0] errcnt_inc;

  always_comb begin
    src_ready = 1'b0;
    src_data  = 32'h0;
    case (addr_q)
      ADDR_VARINT_LO: begin
        src_ready = !varint_out_empty;
        src_data  = varint_out_q[31:0];
      end
      ADDR_VARINT_HI: begin
        src_ready = !varint_out_empty;
        src_data  = varint_out_q[63:32];
      end
      ADDR_RAW: begin
        src_ready = !raw_data_out_empty;
        src_data  = raw_data_out_q;
      end
      ADDR_STATUS: begin
        src_ready = 1'b1;
        src_data  = {errcnt_q, 14'h0, raw_data_out_empty, varint_out_empty};
      end
      default: ;
    endcase
  end

  assign errcnt_inc = (errcnt_q == 16'hFFFF) ? errcnt_q : errcnt_q + 16'd1;

  always_comb begin
    state_d          = state_q;
    rid_d            = rid_q;
    addr_d           = addr_q;
    beat_d           = beat_q;
    tmo_d            = tmo_q;
    errcnt_d         = errcnt_q;
    rdata_d          = rdata_q;
    rresp_d          = rresp_q;
    err_d            = err_q;
    axs_s0_arready   = 1'b0;
    axs_s0_rvalid    = 1'b0;
    axs_s0_rlast     = 1'b0;
    varint_out_pop   = 1'b0;
    raw_data_out_pop = 1'b0;

    case (state_q)
      ST_INIT: begin
        errcnt_d = 16'h0;
        state_d  = ST_AR_READY;
      end

      ST_AR_READY: begin
        axs_s0_arready = 1'b1;
        if (axs_s0_arvalid) begin
          rid_d   = axs_s0_arid;
          addr_d  = axs_s0_araddr[7:0];
          beat_d  = axs_s0_arlen;
          err_d   = !addr_mapped(axs_s0_araddr[7:0]) ||
                    (axs_s0_arsize != SIZE_4B) ||
                    (axs_s0_arburst == BURST_WRAP);
          state_d = ST_FETCH;
        end
      end

      ST_FETCH: begin
        if (err_q) begin
          rdata_d  = 32'h0;
          rresp_d  = RESP_SLVERR;
          errcnt_d = errcnt_inc;
          tmo_d    = 16'h0;
          state_d  = ST_R_VALID;
        end else if (src_ready) begin
          rdata_d          = src_data;
          rresp_d          = RESP_OKAY;
          varint_out_pop   = (addr_q == ADDR_VARINT_HI);
          raw_data_out_pop = (addr_q == ADDR_RAW);
          tmo_d            = 16'h0;
          state_d          = ST_R_VALID;
        end else if (tmo_q == TMO_LAST) begin
          rdata_d  = 32'h0;
          rresp_d  = RESP_SLVERR;
          errcnt_d = errcnt_inc;
          tmo_d    = 16'h0;
          state_d  = ST_R_VALID;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end

      ST_R_VALID: begin
        axs_s0_rvalid = 1'b1;
        axs_s0_rlast  = (beat_q == 8'h0);
        if (axs_s0_rready) begin
          if (beat_q == 8'h0) begin
            state_d = ST_AR_READY;
          end else begin
            // Address is not advanced: FIXED and INCR re-read the same slot
            beat_d  = beat_q - 8'd1;
            state_d = ST_FETCH;
          end
        end
      end

      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_INIT;
      rid_q    <= 4'h0;
      addr_q   <= 8'h0;
      beat_q   <= 8'h0;
      tmo_q    <= 16'h0;
      errcnt_q <= 16'h0;
      rdata_q  <= 32'h0;
      rresp_q  <= 2'b00;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rid_q    <= rid_d;
      addr_q   <= addr_d;
      beat_q   <= beat_d;
      tmo_q    <= tmo_d;
      errcnt_q <= errcnt_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
      err_q    <= err_d;
    end
  end

  assign axs_s0_rid   = rid_q;
  assign axs_s0_rdata = rdata_q;
  assign axs_s0_rresp = rresp_q;

endmodule

// File: tb/tb_axi_rd_fsm.sv
// Directed bench for axi_rd_fsm with EMPTY_TIMEOUT=8: a table of single-beat
// reads plus hand sequences for bursts, backpressure, decode-error bursts,
// a FIFO draining mid-burst and reset mid-burst.
module tb_axi_rd_fsm;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  arid = '0;
  logic [15:0] araddr = '0;
  logic [7:0]  arlen = '0;
  logic [2:0]  arsize = '0;
  logic [1:0]  arburst = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid;
  logic        rready = 1'b0;
  logic [63:0] varint_out_q;
  logic        varint_out_empty, varint_out_pop;
  logic [31:0] raw_data_out_q;
  logic        raw_data_out_empty, raw_data_out_pop;

  axi_rd_fsm #(.EMPTY_TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .axs_s0_arid(arid), .axs_s0_araddr(araddr), .axs_s0_arlen(arlen),
    .axs_s0_arsize(arsize), .axs_s0_arburst(arburst),
    .axs_s0_arvalid(arvalid), .axs_s0_arready(arready),
    .axs_s0_rid(rid), .axs_s0_rdata(rdata), .axs_s0_rresp(rresp),
    .axs_s0_rlast(rlast), .axs_s0_rvalid(rvalid), .axs_s0_rready(rready),
    .varint_out_q(varint_out_q), .varint_out_empty(varint_out_empty),
    .varint_out_pop(varint_out_pop),
    .raw_data_out_q(raw_data_out_q), .raw_data_out_empty(raw_data_out_empty),
    .raw_data_out_pop(raw_data_out_pop)
  );

  initial forever #5 clk = ~clk;

  // Show-ahead FIFO models: pushes from the stimulus, pops from the DUT
  logic [63:0] vmem [16];
  logic [31:0] rmem [16];
  int vwr = 0, vrd = 0, rwr = 0, rrd = 0;
  int pop_viol = 0;

  assign varint_out_empty   = (vwr == vrd);
  assign varint_out_q       = vmem[vrd[3:0]];
  assign raw_data_out_empty = (rwr == rrd);
  assign raw_data_out_q     = rmem[rrd[3:0]];

  always @(posedge clk) begin
    if (varint_out_pop) vrd <= vrd + 1;
    if (raw_data_out_pop) rrd <= rrd + 1;
    if (rvalid && (varint_out_pop || raw_data_out_pop)) pop_viol <= pop_viol + 1;
  end

  int n_vec = 0, n_miss = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic push_v(input logic [63:0] v);
    vmem[vwr[3:0]] = v;
    vwr++;
  endtask

  task automatic push_r(input logic [31:0] v);
    rmem[rwr[3:0]] = v;
    rwr++;
  endtask

  // Results of the last do_read
  logic [31:0] bd [16];
  logic [1:0]  br [16];
  logic        bl [16];
  logic [3:0]  bid [16];
  int          nb, first_rv;

  // Issue one AR and collect len+1 beats. Runs on negedges. With toggle=1,
  // rready alternates 0/1 starting at 0 and held data is checked for stability.
  task automatic do_read(input logic [3:0] id, input logic [7:0] addr,
                         input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input bit toggle);
    int cyc;
    bit ph, hold_v;
    logic [31:0] hold_d;
    logic [1:0]  hold_r;
    arid = id; araddr = {8'hA5, addr}; arlen = len;
    arsize = size; arburst = burst; arvalid = 1'b1;
    cyc = 0;
    while (!arready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    if (!arready) begin
      n_vec++; n_miss++;
      $display("FAIL ar_handshake: arready never high, expected 1");
    end
    @(negedge clk);
    arvalid = 1'b0;
    nb = 0; first_rv = -1; cyc = 0; ph = 1'b0; hold_v = 1'b0;
    hold_d = '0; hold_r = '0;
    while (nb < int'(len) + 1 && cyc < 300) begin
      if (toggle) begin
        rready = ph;
        ph = ~ph;
      end else begin
        rready = 1'b1;
      end
      if (rvalid) begin
        if (first_rv < 0) first_rv = cyc;
        if (hold_v) begin
          chk("hold_rdata", rdata, hold_d);
          chk("hold_rresp", {30'h0, rresp}, {30'h0, hold_r});
        end
        if (rready) begin
          bd[nb] = rdata; br[nb] = rresp; bl[nb] = rlast; bid[nb] = rid;
          nb++;
          hold_v = 1'b0;
        end else begin
          hold_v = 1'b1; hold_d = rdata; hold_r = rresp;
        end
      end
      @(negedge clk);
      cyc++;
    end
    rready = 1'b0;
    chk("beat_count", nb, int'(len) + 1);
  endtask

  typedef struct {
    bit          do_pv;
    logic [63:0] pv;
    bit          do_pr;
    logic [31:0] pr;
    logic [7:0]  addr;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [31:0] exp_d;
    logic [1:0]  exp_r;
    int          exp_vp;
    int          exp_rp;
    int          exp_lat;
  } vec_t;

  vec_t tbl [13];

  initial begin
    int v0, r0;
    // Running error count shown in the status column: see comments per row.
    tbl[0]  = '{1, 64'h1122_3344_5566_7788, 0, 32'h0, 8'h00, 3'b010, 2'b01, 32'h5566_7788, 2'b00, 0, 0, 1};
    tbl[1]  = '{0, 64'h0, 0, 32'h0,         8'h01, 3'b010, 2'b01, 32'h1122_3344, 2'b00, 1, 0, 1};
    tbl[2]  = '{0, 64'h0, 1, 32'hDEAD_BEEF, 8'hF0, 3'b001, 2'b01, 32'h0,         2'b10, 0, 0, 1}; // err=1
    tbl[3]  = '{0, 64'h0, 0, 32'h0,         8'hF0, 3'b010, 2'b10, 32'h0,         2'b10, 0, 0, 1}; // err=2
    tbl[4]  = '{0, 64'h0, 0, 32'h0,         8'hF0, 3'b010, 2'b00, 32'hDEAD_BEEF, 2'b00, 0, 1, 1};
    tbl[5]  = '{0, 64'h0, 0, 32'h0,         8'h08, 3'b010, 2'b01, 32'h0002_0003, 2'b00, 0, 0, 1};
    tbl[6]  = '{0, 64'h0, 0, 32'h0,         8'hF0, 3'b010, 2'b01, 32'h0,         2'b10, 0, 0, 8}; // err=3
    tbl[7]  = '{0, 64'h0, 0, 32'h0,         8'h08, 3'b010, 2'b01, 32'h0003_0003, 2'b00, 0, 0, 1};
    tbl[8]  = '{0, 64'h0, 0, 32'h0,         8'h00, 3'b010, 2'b01, 32'h0,         2'b10, 0, 0, 8}; // err=4
    tbl[9]  = '{1, 64'hAAAA_BBBB_CCCC_DDDD, 0, 32'h0, 8'h08, 3'b010, 2'b01, 32'h0004_0002, 2'b00, 0, 0, 1};
    tbl[10] = '{0, 64'h0, 0, 32'h0,         8'h01, 3'b010, 2'b01, 32'hAAAA_BBBB, 2'b00, 1, 0, 1};
    tbl[11] = '{0, 64'h0, 0, 32'h0,         8'h09, 3'b010, 2'b01, 32'h0,         2'b10, 0, 0, 1}; // err=5
    tbl[12] = '{0, 64'h0, 0, 32'h0,         8'h08, 3'b010, 2'b01, 32'h0005_0003, 2'b00, 0, 0, 1};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_arready", {31'h0, arready}, 32'h0);
    chk("rst_rvalid", {31'h0, rvalid}, 32'h0);
    chk("rst_rlast", {31'h0, rlast}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_rresp_rid", {26'h0, rresp, rid}, 32'h0);
    chk("rst_pops", {30'h0, varint_out_pop, raw_data_out_pop}, 32'h0);
    reset = 1'b1;
    chk("init_arready", {31'h0, arready}, 32'h0);
    @(negedge clk);
    chk("ready_arready", {31'h0, arready}, 32'h1);

    // Single-beat table
    for (int i = 0; i < 13; i++) begin
      if (tbl[i].do_pv) push_v(tbl[i].pv);
      if (tbl[i].do_pr) push_r(tbl[i].pr);
      v0 = vrd; r0 = rrd;
      do_read(4'(i), tbl[i].addr, 8'd0, tbl[i].size, tbl[i].burst, 1'b0);
      chk($sformatf("t%0d_rdata", i), bd[0], tbl[i].exp_d);
      chk($sformatf("t%0d_rresp", i), {30'h0, br[0]}, {30'h0, tbl[i].exp_r});
      chk($sformatf("t%0d_rlast", i), {31'h0, bl[0]}, 32'h1);
      chk($sformatf("t%0d_rid", i), {28'h0, bid[0]}, 32'(i));
      chk($sformatf("t%0d_lat", i), first_rv, tbl[i].exp_lat);
      chk($sformatf("t%0d_vpop", i), vrd - v0, tbl[i].exp_vp);
      chk($sformatf("t%0d_rpop", i), rrd - r0, tbl[i].exp_rp);
    end

    // Raw burst of 3 under toggling backpressure
    push_r(32'hA0A0_0001); push_r(32'hB0B0_0002); push_r(32'hC0C0_0003);
    r0 = rrd;
    do_read(4'h7, 8'hF0, 8'd2, 3'b010, 2'b01, 1'b1);
    chk("burst_d0", bd[0], 32'hA0A0_0001);
    chk("burst_d1", bd[1], 32'hB0B0_0002);
    chk("burst_d2", bd[2], 32'hC0C0_0003);
    chk("burst_last", {29'h0, bl[0], bl[1], bl[2]}, 32'h1);
    chk("burst_resp", {26'h0, br[0], br[1], br[2]}, 32'h0);
    chk("burst_pops", rrd - r0, 3);

    // Decode-error burst: 4 SLVERR beats, error count 5 -> 9
    r0 = rrd; v0 = vrd;
    do_read(4'h3, 8'h55, 8'd3, 3'b010, 2'b01, 1'b0);
    for (int b = 0; b < 4; b++) begin
      chk($sformatf("derr_d%0d", b), bd[b], 32'h0);
      chk($sformatf("derr_r%0d", b), {30'h0, br[b]}, 32'h2);
      chk($sformatf("derr_l%0d", b), {31'h0, bl[b]}, (b == 3) ? 32'h1 : 32'h0);
    end
    chk("derr_pops", (rrd - r0) + (vrd - v0), 0);
    do_read(4'h1, 8'h08, 8'd0, 3'b010, 2'b01, 1'b0);
    chk("derr_status", bd[0], 32'h0009_0003);

    // FIFO drains mid-burst: beat 0 OKAY, beat 1 times out (error count 10)
    push_r(32'h0D0D_0D0D);
    r0 = rrd;
    do_read(4'h2, 8'hF0, 8'd1, 3'b010, 2'b01, 1'b0);
    chk("drain_d0", bd[0], 32'h0D0D_0D0D);
    chk("drain_r", {28'h0, br[0], br[1]}, 32'h2);
    chk("drain_d1", bd[1], 32'h0);
    chk("drain_pops", rrd - r0, 1);
    do_read(4'h1, 8'h08, 8'd0, 3'b010, 2'b01, 1'b0);
    chk("drain_status", bd[0], 32'h000A_0003);

    // Reset during R_VALID of beat 2 of 4
    for (int k = 0; k < 4; k++) push_r(32'h1000_0000 + 32'(k));
    r0 = rrd;
    arid = 4'h5; araddr = 16'h00F0; arlen = 8'd3; arsize = 3'b010;
    arburst = 2'b01; arvalid = 1'b1;
    for (int c = 0; c < 50 && !arready; c++) @(negedge clk);
    @(negedge clk);
    arvalid = 1'b0;
    rready = 1'b1;
    begin
      int acc;
      acc = 0;
      for (int c = 0; c < 100 && acc < 2; c++) begin
        if (rvalid) acc++;
        @(negedge clk);
      end
    end
    rready = 1'b0;
    for (int c = 0; c < 50 && !rvalid; c++) @(negedge clk);
    chk("mid_rvalid_before", {31'h0, rvalid}, 32'h1);
    chk("mid_beat2_data", rdata, 32'h1000_0002);
    reset = 1'b0;
    #1;
    chk("mid_rst_rvalid", {31'h0, rvalid}, 32'h0);
    chk("mid_rst_arready", {31'h0, arready}, 32'h0);
    chk("mid_rst_pops", {30'h0, varint_out_pop, raw_data_out_pop}, 32'h0);
    chk("mid_rst_rdata", rdata, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    chk("mid_init_arready", {31'h0, arready}, 32'h0);
    @(negedge clk);
    chk("mid_ready_arready", {31'h0, arready}, 32'h1);
    chk("mid_pops", rrd - r0, 3);
    do_read(4'h1, 8'h08, 8'd0, 3'b010, 2'b01, 1'b0);
    chk("mid_status", bd[0], 32'h0000_0001);
    do_read(4'h9, 8'hF0, 8'd0, 3'b010, 2'b00, 1'b0);
    chk("mid_fresh_data", bd[0], 32'h1000_0003);
    chk("mid_fresh_resp", {29'h0, br[0], bl[0]}, 32'h1);
    chk("mid_fresh_rid", {28'h0, bid[0]}, 32'h9);

    chk("pop_during_rvalid", pop_viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/axi_rd_fsm.md
Name: axi_rd_fsm

Overview:
- AXI4 read-channel slave on the same s0 port as the write-side FIFO loader. It returns results produced by the varint/raw-data engines to the host.
- Pops two show-ahead output FIFOs: varint_out (64-bit decoded values) and raw_data_out (32-bit words).
- Exposes a read-only status word.
- Each beat goes through FETCH then R_VALID. Empty-FIFO stalls are bounded by a timeout.

Parameters:
- EMPTY_TIMEOUT, 1024, cycles a beat may wait on an empty FIFO before returning SLVERR; range 1..65535.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- axs_s0_arid  in  4  read ID
- axs_s0_araddr  in  16  read address; only [7:0] decoded
- axs_s0_arlen  in  8  beats minus 1
- axs_s0_arsize  in  3  must be 3'b010
- axs_s0_arburst  in  2  FIXED/INCR accepted
- axs_s0_arvalid  in  1  address valid
- axs_s0_arready  out  1  address ready
- axs_s0_rid  out  4  echoed arid
- axs_s0_rdata  out  32  read data
- axs_s0_rresp  out  2  OKAY=2'b00, SLVERR=2'b10
- axs_s0_rlast  out  1  final beat
- axs_s0_rvalid  out  1  data valid
- axs_s0_rready  in  1  master ready
- varint_out_q  in  64  varint FIFO head (show-ahead)
- varint_out_empty  in  1  varint FIFO empty
- varint_out_pop  out  1  one-cycle pop
- raw_data_out_q  in  32  raw FIFO head (show-ahead)
- raw_data_out_empty  in  1  raw FIFO empty
- raw_data_out_pop  out  1  one-cycle pop

Behaviour:
- Reset: all outputs 0. Internal registers (rid, addr, beat count, timeout counter, error counter, rdata, rresp) clear to 0. State goes to INIT.
- Reset mid-burst: the burst is abandoned and no pop is issued.
- INIT: lasts one cycle, then AR_READY. The error counter is cleared only here.

Address map (araddr[7:0]):
- 0x00: varint low word [31:0]; no pop.
- 0x01: varint high word [63:32]; pops.
- 0xF0: raw word; pops.
- 0x08: status. Bit 0 = varint_out_empty, bit 1 = raw_data_out_empty, bits [15:2] = 0, bits [31:16] = error count. Never pops, never waits.
- Any other address: decode error.

AR_READY:
- arready=1.
- On arvalid: latch arid, araddr[7:0], and arlen as the beat counter. Compute err_q = (unmapped addr) OR (arsize != 3'b010) OR (arburst == WRAP). Go to FETCH.

FETCH:
- arready=0, rvalid=0.
- If err_q: rdata_q=0, rresp_q=SLVERR, then R_VALID.
- Else if source FIFO non-empty, or address is 0x08: capture data into rdata_q, rresp_q=OKAY. Assert the pop for one cycle if the address is 0x01 or 0xF0. Go to R_VALID.
- Else: increment the timeout counter. When it reaches EMPTY_TIMEOUT-1, return rdata 0 with SLVERR, no pop, then R_VALID.
- The timeout counter clears on every exit from FETCH.

R_VALID:
- rvalid=1; rdata/rresp come from registers; rid = latched ID; rlast = (beat count == 0).
- rready=0: hold all R outputs stable.
- rready=1 and rlast: go to AR_READY.
- rready=1 and not rlast: decrement beat count, go to FETCH.

Address and burst handling:
- Address is not incremented; FIXED and INCR both re-read the same location.
- Every SLVERR beat increments the error counter, saturating at 0xFFFF.
- A decode error still completes all arlen+1 beats.

Timing:
- Latency: AR handshake at cycle N, FETCH at N+1, rvalid at N+2 when the FIFO is non-empty.
- Each beat costs at least two cycles.

Boundary cases:
- Pop happens only in FETCH, so at most one pop per beat. The FIFO is never popped while rvalid=1, so rdata stays stable under backpressure.
- A FIFO emptied mid-burst stalls only that beat.
- An unknown state encoding goes to INIT.

Decomposition:
- fsm_pkg holds: address constants (VARINT_LO=8'h00, VARINT_HI=8'h01, STATUS=8'h08, RAW=8'hF0), RESP_OKAY/RESP_SLVERR, BURST_FIXED/INCR/WRAP, and the one-hot state encoding (INIT, AR_READY, FETCH, R_VALID). The write-side FSM uses the same package.
- No sub-module is required. The timeout and saturating error counters stay inline.

Test Plan:
- Varint FIFO holds 64'h1122_3344_5566_7788. Read 0x00, arlen=0, then 0x01, arlen=0 -> rdata 32'h5566_7788 with no pop, then 32'h1122_3344 with exactly one varint_out_pop. Both OKAY with rlast=1.
- Raw FIFO holds 3 words A, B, C. Read 0xF0 with arlen=2, INCR, rready toggling 1/0 -> beats A, B, C in order. rlast only on C, three pops, rdata stable while rready=0.
- Raw FIFO empty, EMPTY_TIMEOUT=8, read 0xF0 -> rvalid asserts 8 cycles after FETCH entry with rdata 0 and SLVERR. No pop; status bits [31:16] read back 1.
- Read 0x55 with arlen=3 -> four beats, all SLVERR with rdata 0, rlast on the 4th. No pops; error count +4.
- arsize=3'b001 at 0xF0, or arburst=WRAP -> SLVERR and no pop. Status read 0x08 with both FIFOs empty -> 32'h0000_0003 with the error count in the upper half.
- Reset asserted during R_VALID of beat 2 of 4 -> rvalid/arready/pops drop to 0 immediately. After release the block spends one INIT cycle, then arready=1, and a fresh read completes normally.
